data_parser: RTL and testbench
==============================

DATA_PARSER -- requirements
Module: data_parser

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately; release synchronous to clk).
REQ-003 in_byte  input  8  incoming link byte.
REQ-004 in_valid  input  1  in_byte valid; a byte is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-005 in_ready  output  1  parser can accept a byte this cycle.
REQ-006 data_in_prefix  output  64  prefix of current data packet, to FIB.
REQ-007 data_in_len  output  6  prefix length of current data packet, to FIB.
REQ-008 data_ready  output  1  one-cycle pulse announcing data_in_prefix/len to FIB.
REQ-009 ready_for_data  input  1  FIB accepted data; payload streaming begins.
REQ-010 rejected  input  1  PIT rejected data; payload is dropped.
REQ-011 data_in  output  8  payload byte to FIB.
REQ-012 data_in_valid  output  1  data_in holds a payload byte this cycle.
REQ-013 int_prefix  output  64  prefix of interest packet, to PIT.
REQ-014 int_len  output  6  prefix length of interest packet, to PIT.
REQ-015 int_valid  output  1  one-cycle pulse announcing int_prefix/len.
REQ-016 err  output  1  one-cycle pulse on bad type byte or FIB timeout.

Function
REQ-017 Packet format SHALL be: header byte {type[7:6], len[5:0]}, then 8 prefix bytes MSB first; data packets (type 2'b01) then carry exactly 1024 payload bytes; interest packets (type 2'b10) carry none.
REQ-018 States SHALL be IDLE, PREFIX, ANNOUNCE, WAIT_FIB, STREAM, DRAIN.
REQ-019 IDLE: in_ready=1; accepted header with type 01/10 latches type and len, clears prefix shift register and count -> PREFIX; type 00/11 -> byte dropped, err pulses next cycle, stay IDLE.
REQ-020 PREFIX: in_ready=1; each accepted byte shifts into prefix LSB end; after 8th byte: data -> ANNOUNCE, interest -> int_valid pulses one cycle with int_prefix/int_len stable -> IDLE.
REQ-021 ANNOUNCE: in_ready=0; data_ready=1 for exactly one cycle; data_in_prefix/len held stable from ANNOUNCE until return to IDLE -> WAIT_FIB.
REQ-022 WAIT_FIB: in_ready=0; ready_for_data=1 -> STREAM; rejected=1 -> DRAIN; both high same cycle -> rejected wins (DRAIN); 255 cycles with neither -> err pulse, DRAIN.
REQ-023 STREAM: in_ready=1; data_in=in_byte and data_in_valid=in_valid combinationally (zero latency); 10-bit counter increments per accepted byte; after byte 1024 (count 1023 accepted) -> IDLE.
REQ-024 DRAIN: in_ready=1, data_in_valid=0; consume 1024 payload bytes, then -> IDLE.
REQ-025 Gaps (in_valid=0) in any byte-consuming state SHALL stall counters without error.
REQ-026 Payload counter SHALL clear on entry to STREAM/DRAIN; no wrap beyond 1023.
REQ-027 ready_for_data/rejected outside WAIT_FIB SHALL be ignored.

Reset
REQ-028 On rst=0: state=IDLE, all counters 0, data_in_prefix=0, data_in_len=0, int_prefix=0, int_len=0, data_ready=0, int_valid=0, err=0, data_in_valid=0, data_in=0; in_ready=1 after release.
REQ-029 Reset mid-packet SHALL abandon the packet; the next accepted byte is treated as a header.

Structure
REQ-030 Shared package ndn_pkg SHALL hold type codes (TYPE_DATA=2'b01, TYPE_INT=2'b10), PREFIX_BYTES=8, PAYLOAD_BYTES=1024, FIB_TIMEOUT=255, and the state enum.
REQ-031 No sub-module; single FSM with prefix shift register, 3-bit prefix counter, 10-bit payload counter, 8-bit timeout counter.

Verification
REQ-032 Header 0x50, prefix 0x0102030405060708, ready_for_data 3 cycles after data_ready -> data_in_prefix=0x0102030405060708, data_in_len=16, 1024 data_in_valid beats, then IDLE.
REQ-033 Header 0x88 + 8 prefix bytes -> int_valid single pulse, int_len=8, no data_ready.
REQ-034 Data packet, rejected=1 and ready_for_data=1 same cycle -> DRAIN, zero data_in_valid beats, 1024 bytes consumed.
REQ-035 Data packet, FIB silent -> err pulse after 255 WAIT_FIB cycles, 1024 bytes drained, next header parsed correctly.
REQ-036 Header 0xC0 -> err pulse, state IDLE; rst=0 during STREAM at byte 500 -> all outputs 0 immediately, next byte parsed as header.

Source files
------------

// File: rtl/data_parser_pkg.sv
// Shared NDN link definitions: packet type codes, sizes and parser states.
package ndn_pkg;

  localparam logic [1:0] TYPE_DATA     = 2'b01;
  localparam logic [1:0] TYPE_INT      = 2'b10;
  localparam int         PREFIX_BYTES  = 8;
  localparam int         PAYLOAD_BYTES = 1024;
  localparam int         FIB_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    ANNOUNCE,
    WAIT_FIB,
    STREAM,
    DRAIN
  } state_e;

endpackage

// File: rtl/data_parser_if.sv
// Parser-side bundle: link byte input, FIB announce/stream, PIT interest, error.
// master = the parser, slave = link source plus FIB/PIT.
interface data_parser_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in_prefix;
  logic [5:0]  data_in_len;
  logic        data_ready;
  logic        ready_for_data;
  logic        rejected;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic [63:0] int_prefix;
  logic [5:0]  int_len;
  logic        int_valid;
  logic        err;

  modport master (
    input  in_byte, in_valid, ready_for_data, rejected,
    output in_ready, data_in_prefix, data_in_len, data_ready,
           data_in, data_in_valid, int_prefix, int_len, int_valid, err
  );

  modport slave (
    output in_byte, in_valid, ready_for_data, rejected,
    input  in_ready, data_in_prefix, data_in_len, data_ready,
           data_in, data_in_valid, int_prefix, int_len, int_valid, err
  );
endinterface

// File: rtl/data_parser.sv
// NDN link parser: splits header/prefix, announces data packets to the FIB,
// streams or drains their payload, and forwards interests to the PIT.
module data_parser
  import ndn_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  data_parser_if.master bus
);

  localparam logic [2:0] PFX_LAST = 3'(PREFIX_BYTES - 1);
  localparam logic [9:0] PAY_LAST = 10'(PAYLOAD_BYTES - 1);
  localparam logic [7:0] TMO_LAST = 8'(FIB_TIMEOUT - 1);

  state_e      state, state_nx;
  logic        is_data;
  logic [5:0]  len_q;
  logic [55:0] prefix_sr;
  logic [2:0]  pfx_cnt;
  logic [9:0]  pay_cnt;
  logic [7:0]  tmo_cnt;
  logic [63:0] data_pfx_q, int_pfx_q;
  logic [5:0]  data_len_q, int_len_q;
  logic        int_valid_q, err_q;

  logic        in_ready_c, data_ready_c, data_in_valid_c;
  logic [7:0]  data_in_c;
  logic        accept, hdr_ok;
  logic [63:0] pfx_full;

  assign accept   = bus.in_valid & in_ready_c;
  assign hdr_ok   = (bus.in_byte[7:6] == TYPE_DATA) || (bus.in_byte[7:6] == TYPE_INT);
  // The 8th prefix byte completes the prefix without a separate shift cycle.
  assign pfx_full = {prefix_sr, bus.in_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    in_ready_c      = 1'b0;
    data_ready_c    = 1'b0;
    data_in_c       = '0;
    data_in_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && hdr_ok) state_nx = PREFIX;
      end
      PREFIX: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && pfx_cnt == PFX_LAST) state_nx = is_data ? ANNOUNCE : IDLE;
      end
      ANNOUNCE: begin
        data_ready_c = 1'b1;
        state_nx     = WAIT_FIB;
      end
      WAIT_FIB: begin
        // A PIT reject overrides a simultaneous FIB accept.
        if (bus.rejected)             state_nx = DRAIN;
        else if (bus.ready_for_data)  state_nx = STREAM;
        else if (tmo_cnt == TMO_LAST) state_nx = DRAIN;
      end
      STREAM: begin
        in_ready_c      = 1'b1;
        data_in_c       = bus.in_byte;
        data_in_valid_c = bus.in_valid;
        if (bus.in_valid && pay_cnt == PAY_LAST) state_nx = IDLE;
      end
      DRAIN: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && pay_cnt == PAY_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_data     <= 1'b0;
      len_q       <= '0;
      prefix_sr   <= '0;
      pfx_cnt     <= '0;
      pay_cnt     <= '0;
      tmo_cnt     <= '0;
      data_pfx_q  <= '0;
      data_len_q  <= '0;
      int_pfx_q   <= '0;
      int_len_q   <= '0;
      int_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      int_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (hdr_ok) begin
            is_data   <= (bus.in_byte[7:6] == TYPE_DATA);
            len_q     <= bus.in_byte[5:0];
            prefix_sr <= '0;
            pfx_cnt   <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        PREFIX: if (accept) begin
          prefix_sr <= pfx_full[55:0];
          pfx_cnt   <= pfx_cnt + 1'b1;
          if (pfx_cnt == PFX_LAST) begin
            if (is_data) begin
              data_pfx_q <= pfx_full;
              data_len_q <= len_q;
            end else begin
              int_pfx_q   <= pfx_full;
              int_len_q   <= len_q;
              int_valid_q <= 1'b1;
            end
          end
        end
        ANNOUNCE: tmo_cnt <= '0;
        WAIT_FIB: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          pay_cnt <= '0;
          if (!bus.rejected && !bus.ready_for_data && tmo_cnt == TMO_LAST) err_q <= 1'b1;
        end
        STREAM, DRAIN: if (accept) pay_cnt <= pay_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.data_ready     = data_ready_c;
  assign bus.data_in        = data_in_c;
  assign bus.data_in_valid  = data_in_valid_c;
  assign bus.data_in_prefix = data_pfx_q;
  assign bus.data_in_len    = data_len_q;
  assign bus.int_prefix     = int_pfx_q;
  assign bus.int_len        = int_len_q;
  assign bus.int_valid      = int_valid_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_data_parser.sv
// Scoreboard bench for data_parser: stimulus pushes expected announces,
// interests, payload beats and errors; a negedge monitor pops and compares.
module tb_data_parser;

  typedef struct {
    logic [63:0] prefix;
    logic [5:0]  len;
  } ann_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ann_t       exp_ann[$];
  ann_t       exp_int[$];
  logic [7:0] exp_beat[$];
  int         exp_err[$];

  data_parser_if bus();

  data_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=event want=none", name);
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    ann_t a;
    if (bus.data_ready) begin
      if (exp_ann.size() == 0) unexpected("data_ready_unexpected");
      else begin
        a = exp_ann.pop_front();
        check("ann_prefix", bus.data_in_prefix, a.prefix);
        check("ann_len", 64'(bus.data_in_len), 64'(a.len));
      end
    end
    if (bus.int_valid) begin
      if (exp_int.size() == 0) unexpected("int_valid_unexpected");
      else begin
        a = exp_int.pop_front();
        check("int_prefix", bus.int_prefix, a.prefix);
        check("int_len", 64'(bus.int_len), 64'(a.len));
      end
    end
    if (bus.data_in_valid) begin
      if (exp_beat.size() == 0) unexpected("beat_unexpected");
      else check("beat_byte", 64'(bus.data_in), 64'(exp_beat.pop_front()));
    end
    if (bus.err) begin
      if (exp_err.size() == 0) unexpected("err_unexpected");
      else begin
        total++;
        void'(exp_err.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) unexpected("send_stuck");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_hdr_prefix(input logic [7:0] hdr, input logic [63:0] pfx, input bit gaps);
    logic [63:0] p;
    p = pfx;
    send_byte(hdr);
    for (int i = 7; i >= 0; i--) begin
      send_byte(p[i*8 +: 8]);
      if (gaps && i == 4) idle(2);
    end
  endtask

  task automatic push_ann(input logic [63:0] p, input logic [5:0] l);
    ann_t a;
    a.prefix = p; a.len = l;
    exp_ann.push_back(a);
  endtask

  task automatic push_int(input logic [63:0] p, input logic [5:0] l);
    ann_t a;
    a.prefix = p; a.len = l;
    exp_int.push_back(a);
  endtask

  // Drained payload uses 0x3C: a misplaced header boundary shows up as err.
  task automatic send_payload(input int n, input bit beats);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = beats ? 8'(i) : 8'h3C;
      if (beats) exp_beat.push_back(b);
      send_byte(b);
      if (i % 200 == 199) idle(1);
    end
  endtask

  // Returns in the first WAIT_FIB cycle, #1 after the edge.
  task automatic wait_data_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.data_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.data_ready) unexpected("data_ready_missing");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_byte = '0; bus.in_valid = 1'b0;
    bus.ready_for_data = 1'b0; bus.rejected = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_ready", 64'(bus.data_ready), 0);
    check("rst_int_valid", 64'(bus.int_valid), 0);
    check("rst_err", 64'(bus.err), 0);
    check("rst_data_in_valid", 64'(bus.data_in_valid), 0);
    check("rst_data_in_prefix", bus.data_in_prefix, 0);
    check("rst_int_len", 64'(bus.int_len), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 1);

    // Data packet accepted by FIB three cycles after the announce.
    push_ann(64'h0102030405060708, 6'd16);
    send_hdr_prefix(8'h50, 64'h0102030405060708, 1'b1);
    wait_data_ready();
    idle(2);
    bus.ready_for_data = 1'b1;
    @(posedge clk); #1;
    bus.ready_for_data = 1'b0;
    send_payload(1024, 1'b1);
    check("post_stream_in_ready", 64'(bus.in_ready), 1);

    // Interest right after the stream proves the 1025th byte is a header.
    push_int(64'hA1A2A3A4A5A6A7A8, 6'd8);
    send_hdr_prefix(8'h88, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    idle(3);

    // Reject and accept together: reject wins, payload drained.
    push_ann(64'h1122334455667788, 6'd5);
    send_hdr_prefix(8'h45, 64'h1122334455667788, 1'b0);
    wait_data_ready();
    bus.ready_for_data = 1'b1; bus.rejected = 1'b1;
    @(negedge clk);
    check("wait_fib_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.ready_for_data = 1'b0; bus.rejected = 1'b0;
    send_payload(1024, 1'b0);
    push_int(64'h0000000000000001, 6'd63);
    send_hdr_prefix(8'hBF, 64'h0000000000000001, 1'b0);
    idle(3);

    // FIB silent: err 256 cycles after the announce, then drain.
    push_ann(64'hFFEEDDCCBBAA9988, 6'd32);
    exp_err.push_back(1);
    send_hdr_prefix(8'h60, 64'hFFEEDDCCBBAA9988, 1'b0);
    wait_data_ready();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.err && n < 400);
    check("timeout_cycles", 64'(n), 256);
    @(posedge clk); #1;
    send_payload(1024, 1'b0);
    push_int(64'h8877665544332211, 6'd2);
    send_hdr_prefix(8'h82, 64'h8877665544332211, 1'b1);
    idle(3);

    // Bad type bytes are dropped with an err pulse.
    exp_err.push_back(1);
    send_byte(8'hC0);
    exp_err.push_back(1);
    send_byte(8'h00);
    idle(2);
    check("bad_hdr_in_ready", 64'(bus.in_ready), 1);

    // Reset mid-stream at byte 500.
    push_ann(64'hDEADBEEF00112233, 6'd10);
    send_hdr_prefix(8'h4A, 64'hDEADBEEF00112233, 1'b0);
    wait_data_ready();
    bus.ready_for_data = 1'b1;
    @(posedge clk); #1;
    bus.ready_for_data = 1'b0;
    send_payload(500, 1'b1);
    bus.in_byte = 8'hAA; bus.in_valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_data_in_valid", 64'(bus.data_in_valid), 0);
    check("mid_rst_data_in", 64'(bus.data_in), 0);
    check("mid_rst_data_in_prefix", bus.data_in_prefix, 0);
    check("mid_rst_data_in_len", 64'(bus.data_in_len), 0);
    check("mid_rst_int_prefix", bus.int_prefix, 0);
    check("mid_rst_int_len", 64'(bus.int_len), 0);
    check("mid_rst_err", 64'(bus.err), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;
    push_int(64'h0F0E0D0C0B0A0908, 6'd5);
    send_hdr_prefix(8'h85, 64'h0F0E0D0C0B0A0908, 1'b0);
    idle(5);

    check("left_ann", 64'(exp_ann.size()), 0);
    check("left_int", 64'(exp_int.size()), 0);
    check("left_beat", 64'(exp_beat.size()), 0);
    check("left_err", 64'(exp_err.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
